// File: rtl/csa_pkg.sv
// Shared definitions for the sequential carry-select subtractor:
// FSM state encoding and the slice-count / index-width helpers.
package csa_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

    // Number of CHUNK-bit slices making up one WIDTH-bit operand.
    function automatic int nchunk_f(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of the slice index; a single slice still needs a 1-bit index.
    function automatic int idx_width_f(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/csa_chunk.sv
// CHUNK-bit carry-select slice: two ripple chains, one assuming carry-in 0
// and one assuming carry-in 1, evaluated in parallel. carry_sel picks the
// sum and carry-out of the chain that matches the real incoming carry.
module csa_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_sel,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0]   c0_s;
    logic [CHUNK:0]   c1_s;
    logic [CHUNK-1:0] s0_s;
    logic [CHUNK-1:0] s1_s;

    assign c0_s[0] = 1'b0;
    assign c1_s[0] = 1'b1;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa0 (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c0_s[i]),
            .s    (s0_s[i]),
            .cout (c0_s[i+1])
        );
        full_adder u_fa1 (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c1_s[i]),
            .s    (s1_s[i]),
            .cout (c1_s[i+1])
        );
    end

    // Select the precomputed chain matching the incoming carry.
    always_comb begin
        if (carry_sel) begin
            sum  = s1_s;
            cout = c1_s[CHUNK];
        end else begin
            sum  = s0_s;
            cout = c0_s[CHUNK];
        end
    end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the carry-select slices.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/csa_subtractor_seq.sv
// Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH) with borrow out.
// Computes a + ~b + ~bin one CHUNK-bit carry-select slice per cycle.
// Optional build macro CSA_SUB_OVF_EN adds the signed overflow output ovf.
module csa_subtractor_seq
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef CSA_SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
    localparam int IW     = idx_width_f(NCHUNK);

    state_t                         state_q, state_d;
    logic [NCHUNK-1:0][CHUNK-1:0]   a_q, a_d;
    logic [NCHUNK-1:0][CHUNK-1:0]   nb_q, nb_d;
    logic [NCHUNK-1:0][CHUNK-1:0]   diff_q, diff_d;
    logic                           carry_q, carry_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic                           bout_q, bout_d;
`ifdef CSA_SUB_OVF_EN
    logic                           ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0] sum_s;
    logic             cout_s;
    logic             last_s;

    assign last_s = (idx_q == IW'(NCHUNK - 1));

    csa_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a         (a_q[idx_q]),
        .b         (nb_q[idx_q]),
        .carry_sel (carry_q),
        .sum       (sum_s),
        .cout      (cout_s)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            nb_q    <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            bout_q  <= 1'b0;
`ifdef CSA_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            diff_q  <= diff_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            bout_q  <= bout_d;
`ifdef CSA_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state logic: accept in IDLE, step slices in CALC, wait for the consumer in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = CALC;
                else          state_d = IDLE;
            end
            CALC: begin
                if (last_s) state_d = DONE;
                else        state_d = CALC;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
                else           state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then write one selected slice per CALC cycle.
    always_comb begin
        a_d     = a_q;
        nb_d    = nb_q;
        diff_d  = diff_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        bout_d  = bout_q;
`ifdef CSA_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = ~bin;
                    idx_d   = '0;
                end else begin
                    idx_d   = '0;
                end
            end
            CALC: begin
                diff_d[idx_q] = sum_s;
                carry_d       = cout_s;
                idx_d         = idx_q + IW'(1);
                if (last_s) begin
                    bout_d = ~cout_s;
`ifdef CSA_SUB_OVF_EN
                    // Operand signs differ (a MSB equals inverted-b MSB) and result sign differs from a.
                    ovf_d  = (a_q[NCHUNK-1][CHUNK-1] == nb_q[NCHUNK-1][CHUNK-1]) &&
                             (sum_s[CHUNK-1] != a_q[NCHUNK-1][CHUNK-1]);
`endif
                end else begin
                    bout_d = bout_q;
                end
            end
            DONE: begin
                idx_d = '0;
            end
            default: begin
                idx_d = '0;
            end
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            CALC:    in_ready  = 1'b0;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    assign diff = diff_q;
    assign bout = bout_q;
`ifdef CSA_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_csa_subtractor_seq.sv
// Self-checking bench for csa_subtractor_seq (WIDTH=16, CHUNK=4).
// Expected results come from plain integer subtraction kept in a queue;
// a monitor compares every cycle the result is valid, including latency,
// backpressure hold, in_ready behaviour and reset values.
module tb_csa_subtractor_seq;

    localparam int W  = 16;
    localparam int NC = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          bin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  diff;
    logic          bout;
`ifdef CSA_SUB_OVF_EN
    logic          ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           rise;
    } exp_t;

    exp_t q[$];
    bit   seen_valid    = 1'b0;
    bit   chk_reset     = 1'b0;
    bit   chk_ready_nxt = 1'b0;

    csa_subtractor_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
`ifdef CSA_SUB_OVF_EN
        .bout      (bout),
        .ovf       (ovf)
`else
        .bout      (bout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                   input logic bi_n, input int rise);
        exp_t e;
        logic [W:0] t;
        int sr;
        t      = {1'b0, ai} - {1'b0, bi} - {{W{1'b0}}, bi_n};
        sr     = int'($signed(ai)) - int'($signed(bi)) - int'(bi_n);
        e.d    = t[W-1:0];
        e.bo   = t[W];
        e.ov   = (sr < -32768) || (sr > 32767);
        e.rise = rise;
        return e;
    endfunction

    // Monitor: compares outputs against the queued model every falling edge.
    always @(negedge clk) begin
        if (chk_reset) begin
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_bout", 32'(bout), 32'd0);
            chk("rst_diff", 32'(diff), 32'd0);
`ifdef CSA_SUB_OVF_EN
            chk("rst_ovf", 32'(ovf), 32'd0);
`endif
            chk_reset = 1'b0;
        end
        if (rst) begin
            q.delete();
            seen_valid    = 1'b0;
            chk_ready_nxt = 1'b0;
            chk_reset     = 1'b1;
        end else begin
            if (chk_ready_nxt) begin
                chk("in_ready_after_hs", 32'(in_ready), 32'd1);
                chk("out_valid_after_hs", 32'(out_valid), 32'd0);
                chk_ready_nxt = 1'b0;
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!seen_valid) begin
                        chk("latency", 32'(cyc), 32'(q[0].rise));
                        seen_valid = 1'b1;
                    end
                    chk("diff", 32'(diff), 32'(q[0].d));
                    chk("bout", 32'(bout), 32'(q[0].bo));
`ifdef CSA_SUB_OVF_EN
                    chk("ovf", 32'(ovf), 32'(q[0].ov));
`endif
                    chk("in_ready_busy", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen_valid    = 1'b0;
                        chk_ready_nxt = 1'b1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, bin, cyc + 1 + NC));
            end
        end
    end

    // One operation: offer operands, wait for accept, scramble inputs, wait for result.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bi_n,
                          input int hold, input bit lit, input logic [W-1:0] ld,
                          input logic lb, input logic lo);
        int n;
        @(posedge clk); #1;
        a = ai; b = bi; bin = bi_n; in_valid = 1'b1;
        out_ready = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk("result_timeout", 32'(out_valid), 32'd1);
            return;
        end
        if (lit) begin
            chk("lit_diff", 32'(diff), 32'(ld));
            chk("lit_bout", 32'(bout), 32'(lb));
`ifdef CSA_SUB_OVF_EN
            chk("lit_ovf", 32'(ovf), 32'(lo));
`endif
        end
        if (hold > 0) begin
            repeat (hold - 1) @(negedge clk);
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b1, 16'h1000, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b1, 0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b0, 0, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_op(16'h00A5, 16'h005A, 1'b0, 5, 1'b1, 16'h004B, 1'b0, 1'b0);

        // Reset asserted during the second CALC cycle.
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h4321; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("pre_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        run_op(16'h00FF, 16'h000F, 1'b0, 0, 1'b1, 16'h00F0, 1'b0, 1'b0);

`ifdef CSA_SUB_OVF_EN
        run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b1, 16'h8000, 1'b1, 1'b1);
        run_op(16'h0003, 16'h0001, 1'b0, 0, 1'b1, 16'h0002, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'b0, 16'h0000, 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_subtractor_seq.md
Name: csa_subtractor_seq

Overview:
- Multi-cycle N-bit subtractor: diff = a - b - bin, with borrow out.
- Processes one CHUNK-bit slice per cycle using carry-select.
- Each slice computes both carry-in=0 and carry-in=1 results in parallel; the registered carry from the previous slice selects between them.
- Sits beside the combinational carry-select adders as the area-lean subtract path, with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK iterations.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow out; 1 when the unsigned result is below 0.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, chunk index=0, carry reg=0.
- Arithmetic: a + ~b + carry_in, with initial carry_in = ~bin. Final bout = ~carry out of the MSB chunk.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, ~b and carry=~bin; idx=0; go to CALC.
  - CALC: each cycle, slice idx computes both sums (carry 0 and carry 1). The carry reg selects the sum and next carry. Write diff[idx*CHUNK +: CHUNK], update the carry reg, idx++. After slice NCHUNK-1, set bout=~carry and go to DONE.
  - DONE: out_valid=1. diff and bout are held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- Latency: acceptance edge, then NCHUNK CALC cycles. out_valid rises on the edge ending the last CALC cycle (4 cycles after accept for defaults).
- No overlap: in_ready=0 in CALC and DONE. in_ready returns one cycle after the output handshake.
- in_valid while busy is ignored; the source must hold it.
- Operands are latched at accept, so input changes during CALC have no effect.
- Reset mid-operation: the operation is abandoned, and the next cycle shows the reset values.
- NCHUNK=1 (CHUNK=WIDTH) is legal: one CALC cycle.
- diff bits not yet written during CALC are don't-care; only values under out_valid are checked.

Optional Feature:
- Macro: CSA_SUB_OVF_EN.
- With it: extra output port ovf (1 bit), the signed two's-complement overflow flag, ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]).
  - Registered together with bout; valid under out_valid; reset 0.
- Without it: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package csa_pkg holds:
  - state encoding constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2;
  - a function computing NCHUNK and the index width (clog2).
- One sub-module, csa_chunk: CHUNK-bit combinational dual-carry slice.
  - Inputs: a, b, carry_sel. Outputs: selected sum and carry out.
  - Built from the existing full_adder cell.

Test Plan (WIDTH=16, CHUNK=4):
1. a=0x1234, b=0x0234, bin=0, out_ready=1 -> diff=0x1000, bout=0; out_valid exactly 4 cycles after accept.
2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1 (borrow ripples through all 4 chunks).
3. a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1; then a=0x0005, b=0x0005, bin=0 -> diff=0x0000, bout=0.
4. Backpressure: result ready, out_ready=0 for 5 cycles -> out_valid stays 1, diff/bout unchanged, in_ready=0. Raise out_ready -> one handshake, then in_ready=1 next cycle.
5. rst=1 during the 2nd CALC cycle -> next cycle in_ready=1, out_valid=0, bout=0. A new op a=0x00FF, b=0x000F yields diff=0x00F0.
6. With CSA_SUB_OVF_EN:
   - a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, bout=0.
   - a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, bout=1.
   - a=0x0003, b=0x0001 -> ovf=0.
